int_mem_sequencer: RTL
======================

# int_mem_sequencer

Interrupt sequencer and data-memory port arbiter in front of the memory stage's data memory. In normal operation it passes pipeline memory requests straight through to the memory port. On an interrupt it stalls the pipeline and lets the in-flight memory access drain. It then takes the port to push the return PC (32-bit) and the flags (16-bit) onto the stack, reads the 32-bit interrupt vector, and issues a PC load.

## Interface
Parameters:
- VEC_ADDR, 32'h0000_0000, word address of the 32-bit interrupt vector (two 16-bit words: VEC_ADDR, VEC_ADDR+1)

Ports:
- clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_int  in  1  interrupt request; only a 0->1 transition sampled at a clk edge triggers
- i_pipeMemBusy  in  1  memory stage holds an in-flight instruction using memory this cycle
- i_pc  in  32  return PC (next unexecuted instruction)
- i_flags  in  3  {C,N,Z} flags to save
- i_sp  in  32  current stack pointer (points at next free word)
- i_memData  in  32  data-memory read data, valid the cycle after a read request
- i_pMemRead, i_pMemWrite, i_pEn32  in  1 each  pipeline request controls
- i_pAddr  in  32  pipeline address
- i_pData  in  32  pipeline write data
- o_memRead, o_memWrite, o_en32  out  1 each  data-memory controls
- o_address  out  32  data-memory address
- o_writeData  out  32  data-memory write data
- o_stall  out  1  freeze fetch/decode/execute
- o_spWrite  out  1  load SP with o_newSP at the next edge
- o_newSP  out  32  new stack-pointer value
- o_pcLoad  out  1  one-cycle pulse: load PC with o_pcValue
- o_pcValue  out  32  vector fetched from memory
- o_intAck  out  1  one-cycle pulse, coincident with o_pcLoad

## Operation
- Registered state (one-hot or binary): IDLE, DRAIN, PUSH_PC, PUSH_FLG, READ_VEC, WAIT_VEC, JUMP.
- Edge detector: register i_int. Trigger when the current i_int is 1 and the previous sample is 0, in IDLE only. Edges arriving in any other state are dropped, not queued.
- Latch the return PC and flags into internal registers on the trigger edge.
- IDLE:
  - Memory outputs mirror i_p* combinationally.
  - o_stall=0.
  - On a trigger, go to DRAIN.
- DRAIN:
  - o_stall=1 and memory outputs still mirror i_p*.
  - When i_pipeMemBusy=0, go to PUSH_PC; otherwise stay.
- PUSH_PC:
  - o_memWrite=1, o_en32=1, o_address=SP-1, o_writeData=latched PC.
  - o_spWrite=1, o_newSP=SP-2.
- PUSH_FLG:
  - o_memWrite=1, o_en32=0, o_address=SP (already decremented), o_writeData={29'b0,flags}.
  - o_spWrite=1, o_newSP=SP-1.
- READ_VEC: o_memRead=1, o_en32=1, o_address=VEC_ADDR.
- WAIT_VEC: capture i_memData into the o_pcValue register.
- JUMP: o_pcLoad=1, o_intAck=1, o_stall=1. Next state is IDLE.
- In every state other than IDLE and DRAIN, the i_p* request inputs are ignored (blocked from the port).
- SP arithmetic is 32-bit modulo 2^32; wrap-around is not flagged.
- o_spWrite and o_newSP are combinational from state and i_sp. Other memory outputs are 0 when not driven.

## Timing
- Reset (i_reset=0, async):
  - State goes to IDLE; edge-detect register, latches and o_pcValue clear to 0.
  - o_stall, o_spWrite, o_pcLoad and o_intAck are 0; o_newSP, o_address, o_writeData and the memory controls are 0.
  - Exception: with i_p* inputs active during reset, the memory port outputs still mirror them. Pass-through is combinational.
- Release is synchronous to clk. Reset asserted mid-sequence aborts it: no further memory writes, no o_pcLoad.
- Latency with no drain: trigger at edge N gives DRAIN in cycle N+1, PUSH_PC N+2, PUSH_FLG N+3, READ_VEC N+4, WAIT_VEC N+5, JUMP N+6.
  - o_pcLoad is high for cycle N+6 only.
  - Each cycle of i_pipeMemBusy=1 in DRAIN adds one cycle.
- o_stall is high from cycle N+1 through N+6 inclusive and low in the cycle after JUMP.
- i_int held high after JUMP does not retrigger; a fresh 0->1 is required.
- A trigger and a pipeline request in the same IDLE cycle: the pipeline request is served that cycle.

## Test plan
- Basic interrupt (SP=0x3FF, PC=0x120, flags=3'b101, mem[0..1]=0x0000_0200, busy=0):
  - Write 0x120 at 0x3FE with en32, newSP 0x3FD.
  - Write 0x5 at 0x3FD, newSP 0x3FC.
  - Read at address 0; o_pcLoad with 0x200 at N+6; stall N+1..N+6.
- Drain: i_pipeMemBusy=1 for 3 cycles after the trigger, with a pipeline write to 0x50 → that write appears on the port, PUSH_PC is delayed 3 cycles, and o_pcLoad lands at N+9.
- Pass-through: no interrupt, pipeline read 0x10 en32 → port shows a read of 0x10 en32 the same cycle, o_stall=0.
- Level hold and re-edge:
  - i_int held high 20 cycles → exactly one o_intAck.
  - Dropped and reasserted during PUSH_FLG → ignored.
  - Reasserted after IDLE → second sequence runs.
- Reset mid-sequence: i_reset=0 asynchronously in PUSH_FLG → outputs go to 0 immediately, no o_pcLoad. After release, state is IDLE and pass-through works.
- SP wrap: SP=0x0000_0000 → PUSH_PC address 0xFFFF_FFFF, newSP 0xFFFF_FFFE, then flags at 0xFFFF_FFFE, newSP 0xFFFF_FFFD.

Source files
------------

// File: rtl/int_mem_sequencer.sv
// Interrupt sequencer and data-memory port arbiter: passes pipeline requests through, and on an
// interrupt drains the pipeline, pushes PC and flags, fetches the vector and issues a PC load.
module int_mem_sequencer #(
    parameter logic [31:0] VEC_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_int,
    input  logic        i_pipeMemBusy,
    input  logic [31:0] i_pc,
    input  logic [2:0]  i_flags,
    input  logic [31:0] i_sp,
    input  logic [31:0] i_memData,
    input  logic        i_pMemRead,
    input  logic        i_pMemWrite,
    input  logic        i_pEn32,
    input  logic [31:0] i_pAddr,
    input  logic [31:0] i_pData,
    output logic        o_memRead,
    output logic        o_memWrite,
    output logic        o_en32,
    output logic [31:0] o_address,
    output logic [31:0] o_writeData,
    output logic        o_stall,
    output logic        o_spWrite,
    output logic [31:0] o_newSP,
    output logic        o_pcLoad,
    output logic [31:0] o_pcValue,
    output logic        o_intAck
);

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StPushPc,
        StPushFlg,
        StReadVec,
        StWaitVec,
        StJump
    } state_e;

    state_e      state_q, state_d;
    logic        int_q;
    logic [31:0] pc_q;
    logic [2:0]  flags_q;
    logic [31:0] vec_q;
    logic        trigger;

    // Edges seen outside IDLE are dropped rather than queued.
    assign trigger = (state_q == StIdle) && i_int && !int_q;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            int_q   <= 1'b0;
            pc_q    <= 32'h0;
            flags_q <= 3'b000;
            vec_q   <= 32'h0;
        end else begin
            int_q <= i_int;
            if (trigger) begin
                pc_q    <= i_pc;
                flags_q <= i_flags;
            end
            if (state_q == StWaitVec) begin
                vec_q <= i_memData;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (trigger) state_d = StDrain;
            StDrain:   if (!i_pipeMemBusy) state_d = StPushPc;
            StPushPc:  state_d = StPushFlg;
            StPushFlg: state_d = StReadVec;
            StReadVec: state_d = StWaitVec;
            StWaitVec: state_d = StJump;
            StJump:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        o_memRead   = 1'b0;
        o_memWrite  = 1'b0;
        o_en32      = 1'b0;
        o_address   = 32'h0;
        o_writeData = 32'h0;
        o_stall     = 1'b1;
        o_spWrite   = 1'b0;
        o_newSP     = 32'h0;
        o_pcLoad    = 1'b0;
        o_intAck    = 1'b0;
        unique case (state_q)
            StIdle, StDrain: begin
                // The pipeline keeps the port until its in-flight access has drained.
                o_memRead   = i_pMemRead;
                o_memWrite  = i_pMemWrite;
                o_en32      = i_pEn32;
                o_address   = i_pAddr;
                o_writeData = i_pData;
                o_stall     = (state_q == StDrain);
            end
            StPushPc: begin
                o_memWrite  = 1'b1;
                o_en32      = 1'b1;
                o_address   = i_sp - 32'd1;
                o_writeData = pc_q;
                o_spWrite   = 1'b1;
                o_newSP     = i_sp - 32'd2;
            end
            StPushFlg: begin
                o_memWrite  = 1'b1;
                o_address   = i_sp;
                o_writeData = {29'b0, flags_q};
                o_spWrite   = 1'b1;
                o_newSP     = i_sp - 32'd1;
            end
            StReadVec: begin
                o_memRead = 1'b1;
                o_en32    = 1'b1;
                o_address = VEC_ADDR;
            end
            StWaitVec: begin
            end
            StJump: begin
                o_pcLoad = 1'b1;
                o_intAck = 1'b1;
            end
            default: begin
                o_stall = 1'b0;
            end
        endcase
    end

    assign o_pcValue = vec_q;

endmodule
